// File: rtl/lut_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lut_sweep_ctrl_pkg
// Shared definitions for the LUT sweep controller: FSM state encoding, legal
// ranges for the N_IN / SETTLE parameters, the settle timer width, and a helper
// that checks whether a parameter set is legal.
// -----------------------------------------------------------------------------
package lut_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int N_IN_MIN   = 1;
    localparam int N_IN_MAX   = 8;
    localparam int SETTLE_MIN = 0;
    localparam int SETTLE_MAX = 15;

    // Wide enough to hold SETTLE_MAX.
    localparam int TIMER_W = 4;

    function automatic bit params_legal(input int n_in, input int settle);
        return (n_in >= N_IN_MIN) && (n_in <= N_IN_MAX) &&
               (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Loadable down-counter that measures the settle time of each vector.
//   clk      in   system clock, rising edge
//   rst      in   synchronous, active-high reset (count <= 0)
//   load     in   load load_val this cycle (has priority over counting)
//   load_val in   W  value to load
//   expire   out  high while the count is 1, i.e. the last settle cycle
// The counter stops at 0, so it never wraps while idle.
// -----------------------------------------------------------------------------
module settle_timer
    import lut_sweep_ctrl_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/lut_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// lut_sweep_ctrl
// Sweeps a combinational function block through all 2^N_IN input vectors,
// waits SETTLE cycles per vector, captures lut_out into a truth table and
// compares it against a latched expected table.
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   start       in   request a sweep; only honoured in IDLE
//   expected    in   2^N_IN  expected truth table (bit i = f(i)), latched on start
//   lut_in      out  N_IN    vector driven to the function block (registered)
//   lut_out     in   function block output
//   busy        out  high from start acceptance through the done cycle
//   done        out  one-cycle completion pulse
//   truth_table out  2^N_IN  captured outputs, bit i = lut_out for vector i
//   pass        out  valid with done: captured table matched expected
//   err_count   out  N_IN+1  number of mismatching vectors
//   first_err   out  N_IN    lowest mismatching vector (0 when none)
// -----------------------------------------------------------------------------
module lut_sweep_ctrl
    import lut_sweep_ctrl_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected,
    output logic [N_IN-1:0]       lut_in,
    input  logic                  lut_out,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  truth_table,
    output logic                  pass,
    output logic [N_IN:0]         err_count,
    output logic [N_IN-1:0]       first_err
);

    localparam int NVEC  = 1 << N_IN;
    localparam int ERR_W = N_IN + 1;

    localparam logic [N_IN-1:0]    LAST_IDX  = '1;
    localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE);
    // With no settle time each vector goes straight to its sampling cycle.
    localparam state_t             VEC_ST    = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;

    generate
        if (!params_legal(N_IN, SETTLE)) begin : g_param_guard
            $fatal(1, "lut_sweep_ctrl: N_IN must be 1..8 and SETTLE 0..15");
        end
    endgenerate

    state_t state, state_nxt;

    logic              accept;
    logic              sample_fire;
    logic              timer_load;
    logic              timer_expire;
    logic              last_vec;
    logic              mismatch;
    logic [NVEC-1:0]   exp_q;
    logic [N_IN-1:0]   idx;
    logic [ERR_W-1:0]  err_count_nxt;

    settle_timer #(
        .W (TIMER_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LD),
        .expire   (timer_expire)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        sample_fire = 1'b0;
        timer_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = VEC_ST;
                end
            end
            ST_WAIT: begin
                if (timer_expire) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                sample_fire = 1'b1;
                if (last_vec) begin
                    state_nxt = ST_DONE;
                end else begin
                    timer_load = 1'b1;
                    state_nxt  = VEC_ST;
                end
            end
            ST_DONE: begin
                // start is ignored here; the controller always returns to IDLE.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------ capture and compare
    assign last_vec      = (idx == LAST_IDX);
    assign mismatch      = (lut_out != exp_q[idx]);
    assign err_count_nxt = err_count + ERR_W'(mismatch);

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q       <= '0;
            idx         <= '0;
            truth_table <= '0;
            err_count   <= '0;
            first_err   <= '0;
            pass        <= 1'b0;
        end else if (accept) begin
            exp_q       <= expected;
            idx         <= '0;
            truth_table <= '0;
            err_count   <= '0;
            first_err   <= '0;
            pass        <= 1'b0;
        end else if (sample_fire) begin
            truth_table[idx] <= lut_out;
            if (mismatch) begin
                err_count <= err_count_nxt;
                if (err_count == '0) begin
                    first_err <= idx;
                end
            end
            if (last_vec) begin
                // Park the vector at 0 so lut_in already reads 0 once idle.
                idx  <= '0;
                pass <= (err_count_nxt == '0);
            end else begin
                idx <= idx + N_IN'(1);
            end
        end
    end

    // Decoded from registered state, so both are glitch-free.
    assign lut_in = idx;
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lut_sweep_ctrl
// Two controllers (SETTLE=2 and SETTLE=0, N_IN=4) each drive a table-based
// function block. Every sweep pushes the predicted result (truth table, error
// count, first error, pass, completion cycle) into a per-instance queue; a
// monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_lut_sweep_ctrl;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  err;
        logic [3:0]  first;
        logic        pass;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;

    logic        start2, start0;
    logic [15:0] expected2, expected0;
    logic [3:0]  lut_in2, lut_in0;
    logic        lut_out2, lut_out0;
    logic        busy2, busy0, done2, done0, pass2, pass0;
    logic [15:0] tt2, tt0;
    logic [4:0]  err2, err0;
    logic [3:0]  first2, first0;

    logic [15:0] tbl2, tbl0;

    int checks = 0;
    int errors = 0;

    exp_t q2[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function blocks under test: arbitrary truth tables.
    assign lut_out2 = tbl2[lut_in2];
    assign lut_out0 = tbl0[lut_in0];

    lut_sweep_ctrl #(.N_IN(4), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .expected(expected2),
        .lut_in(lut_in2), .lut_out(lut_out2), .busy(busy2), .done(done2),
        .truth_table(tt2), .pass(pass2), .err_count(err2), .first_err(first2)
    );

    lut_sweep_ctrl #(.N_IN(4), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(expected0),
        .lut_in(lut_in0), .lut_out(lut_out0), .busy(busy0), .done(done0),
        .truth_table(tt0), .pass(pass0), .err_count(err0), .first_err(first0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: the sweep result follows directly from the function
    // table and the expected table; completion time from the vector count.
    function automatic exp_t model(input logic [15:0] tbl, input logic [15:0] expv,
                                   input int acc, input int settle);
        exp_t e;
        int   n;
        n       = 0;
        e.first = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (tbl[i] != expv[i]) begin
                n++;
                e.first = 4'(i);
            end
        end
        e.tt       = tbl;
        e.err      = 5'(n);
        e.pass     = (n == 0);
        e.done_cyc = acc + 16 * (settle + 1);
        return e;
    endfunction

    function automatic logic [15:0] parity_tbl();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) begin
            t[i] = ^(4'(i));
        end
        return t;
    endfunction

    task automatic compare(input string tag, input exp_t e, input logic [15:0] tt,
                           input logic p, input logic [4:0] ec, input logic [3:0] fe,
                           input logic b);
        check({tag, "_done_cycle"},  32'(cyc),     32'(e.done_cyc));
        check({tag, "_truth_table"}, 32'(tt),      32'(e.tt));
        check({tag, "_pass"},        32'(p),       32'(e.pass));
        check({tag, "_err_count"},   32'(ec),      32'(e.err));
        check({tag, "_first_err"},   32'(fe),      32'(e.first));
        check({tag, "_busy_in_done"}, 32'(b),      32'(1));
    endtask

    // ------------------------------------------------------------ monitors
    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            if (q2.size() == 0) begin
                check("s2_unexpected_done", 32'(q2.size()), 32'(1));
            end else begin
                e = q2.pop_front();
                compare("s2", e, tt2, pass2, err2, first2, busy2);
            end
        end
        if (!busy2) begin
            check("s2_idle_lut_in", 32'(lut_in2), 32'(0));
            check("s2_idle_done",   32'(done2),   32'(0));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) begin
                check("s0_unexpected_done", 32'(q0.size()), 32'(1));
            end else begin
                e = q0.pop_front();
                compare("s0", e, tt0, pass0, err0, first0, busy0);
            end
        end
        if (!busy0) begin
            check("s0_idle_lut_in", 32'(lut_in0), 32'(0));
            check("s0_idle_done",   32'(done0),   32'(0));
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic wait_drain(input bit inst0);
        int n;
        n = 0;
        while (((inst0 ? q0.size() : q2.size()) != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(inst0 ? "s0_done_seen" : "s2_done_seen",
              32'(inst0 ? q0.size() : q2.size()), 32'(0));
        if (inst0) q0.delete(); else q2.delete();
    endtask

    // mode: 0 plain, 1 re-pulse start and change expected mid-sweep, 2 walk lut_in
    task automatic sweep2(input logic [15:0] tbl, input logic [15:0] expv, input int mode);
        int   a;
        exp_t e;
        @(negedge clk);
        tbl2      = tbl;
        expected2 = expv;
        start2    = 1'b1;
        @(posedge clk);
        #1;
        a      = cyc;
        start2 = 1'b0;
        e      = model(tbl, expv, a, 2);
        q2.push_back(e);
        if (mode == 1) begin
            repeat (9) @(negedge clk);
            start2    = 1'b1;
            expected2 = ~expv;
            @(negedge clk);
            start2 = 1'b0;
        end else if (mode == 2) begin
            for (int j = 0; j < 48; j++) begin
                check("s2_lut_in_walk", 32'(lut_in2), 32'(j / 3));
                @(posedge clk);
                #1;
            end
        end
        wait_drain(1'b0);
        repeat (3) @(negedge clk);
        check("s2_hold_truth_table", 32'(tt2),  32'(e.tt));
        check("s2_hold_err_count",   32'(err2), 32'(e.err));
    endtask

    task automatic sweep0(input logic [15:0] tbl, input logic [15:0] expv);
        int a;
        @(negedge clk);
        tbl0      = tbl;
        expected0 = expv;
        start0    = 1'b1;
        @(posedge clk);
        #1;
        a      = cyc;
        start0 = 1'b0;
        q0.push_back(model(tbl, expv, a, 0));
        wait_drain(1'b1);
    endtask

    initial begin
        logic [15:0] par;
        logic [15:0] t;
        int          a;
        par       = parity_tbl();
        rst       = 1'b1;
        start2    = 1'b1;
        start0    = 1'b1;
        expected2 = 16'hFFFF;
        expected0 = 16'hFFFF;
        tbl2      = 16'h0000;
        tbl0      = 16'h0000;

        // Reset with start held high: everything stays cleared.
        repeat (2) @(negedge clk);
        check("rst_busy",        32'(busy2), 32'(0));
        check("rst_done",        32'(done2), 32'(0));
        check("rst_lut_in",      32'(lut_in2), 32'(0));
        check("rst_truth_table", 32'(tt2),   32'(0));
        check("rst_pass",        32'(pass2), 32'(0));
        check("rst_err_count",   32'(err2),  32'(0));
        check("rst_first_err",   32'(first2), 32'(0));
        check("rst_busy_s0",     32'(busy0), 32'(0));
        check("rst_tt_s0",       32'(tt0),   32'(0));
        rst    = 1'b0;
        start2 = 1'b0;
        start0 = 1'b0;

        // Directed sweeps on the SETTLE=2 controller.
        sweep2(par, 16'h6996, 0);
        sweep2(par, 16'h6997, 0);
        sweep2(16'h0000, 16'hFFFF, 0);
        sweep2(par, 16'h6996, 1);

        // Reset in the middle of a sweep: abort, no done.
        @(negedge clk);
        tbl2      = par;
        expected2 = 16'h6996;
        start2    = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",        32'(busy2),  32'(0));
        check("abort_lut_in",      32'(lut_in2), 32'(0));
        check("abort_truth_table", 32'(tt2),    32'(0));
        check("abort_err_count",   32'(err2),   32'(0));
        check("abort_first_err",   32'(first2), 32'(0));
        check("abort_pass",        32'(pass2),  32'(0));
        repeat (60) @(negedge clk);
        sweep2(par, 16'h6996, 0);

        // Randomised tables with a sparse set of expected-bit flips.
        for (int k = 0; k < 6; k++) begin
            t = 16'($urandom);
            sweep2(t, t ^ 16'($urandom & $urandom & $urandom), (k == 0) ? 2 : 0);
        end

        // SETTLE=0: one vector per cycle, start held through the done cycle.
        @(negedge clk);
        tbl0      = par;
        expected0 = 16'h6996;
        start0    = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        q0.push_back(model(par, 16'h6996, a, 0));
        q0.push_back(model(par, 16'h6996, a + 18, 0));
        for (int j = 0; j < 16; j++) begin
            check("s0_lut_in_walk", 32'(lut_in0), 32'(j));
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_drain(1'b1);

        for (int k = 0; k < 4; k++) begin
            t = 16'($urandom);
            sweep0(t, t ^ 16'($urandom & $urandom));
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
